// File: rtl/stopwatch_timebase.sv
// rtl/stopwatch_timebase.sv - stopwatch core: tick prescaler, cascaded BCD cs/sec/min counters, lap freeze
//
// Ports:
//   clk        system clock, rising edge
//   reset      asynchronous active-low reset
//   start_stop one-cycle pulse, toggles running
//   clear      one-cycle pulse, zeroes prescaler, count, overflow and freeze
//   lap        one-cycle pulse, toggles display freeze (captures live count when freezing)
//   running    high while counting
//   frozen     high while the BCD outputs show the lap hold registers
//   cs_bcd     centiseconds, two BCD digits
//   sec_bcd    seconds, two BCD digits
//   min_bcd    minutes, two BCD digits
//   tick_cs    one-cycle pulse on each live centisecond increment
//   tick_sec   one-cycle pulse on each live seconds increment
//   tick_min   one-cycle pulse on each live minutes increment
//   overflow   sticky, set when the count passes MAX_MIN:59:99
module stopwatch_timebase #(
    parameter int CLK_HZ  = 50_000_000,
    parameter int TICK_HZ = 100,
    parameter int MAX_MIN = 99,
    parameter int WRAP    = 1
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       start_stop,
    input  logic       clear,
    input  logic       lap,
    output logic       running,
    output logic       frozen,
    output logic [7:0] cs_bcd,
    output logic [7:0] sec_bcd,
    output logic [7:0] min_bcd,
    output logic       tick_cs,
    output logic       tick_sec,
    output logic       tick_min,
    output logic       overflow
);

    localparam int DIV = CLK_HZ / TICK_HZ;
    localparam int PW  = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [PW-1:0] PRESC_LAST  = PW'(DIV - 1);
    localparam logic [7:0]    MAX_MIN_BCD = 8'(((MAX_MIN / 10) * 16) + (MAX_MIN % 10));
    localparam bit            WRAP_EN     = (WRAP != 0);

    logic [PW-1:0] presc_q, presc_d;
    logic [7:0]    cs_q, cs_d, sec_q, sec_d, min_q, min_d;
    logic [7:0]    hold_cs_q, hold_cs_d, hold_sec_q, hold_sec_d, hold_min_q, hold_min_d;
    logic          running_q, running_d, frozen_q, frozen_d, overflow_q, overflow_d;
    logic          tick_cs_q, tick_cs_d, tick_sec_q, tick_sec_d, tick_min_q, tick_min_d;
    logic          tc, cs_wrap, sec_wrap, ovf_evt, ss_allowed;

    // Two-digit BCD increment; callers handle the 99/59 wrap themselves.
    function automatic logic [7:0] bcd_inc(input logic [7:0] v);
        if (v[3:0] == 4'd9) begin
            return {v[7:4] + 4'd1, 4'd0};
        end
        return {v[7:4], v[3:0] + 4'd1};
    endfunction

    assign tc       = running_q && (presc_q == PRESC_LAST);
    assign cs_wrap  = (cs_q == 8'h99);
    assign sec_wrap = (sec_q == 8'h59);
    assign ovf_evt  = tc && cs_wrap && sec_wrap && (min_q == MAX_MIN_BCD);
    // A saturated stopwatch only restarts after clear; a coincident clear unlocks it.
    assign ss_allowed = WRAP_EN || !overflow_q || clear;

    always_comb begin
        presc_d    = presc_q;
        cs_d       = cs_q;
        sec_d      = sec_q;
        min_d      = min_q;
        hold_cs_d  = hold_cs_q;
        hold_sec_d = hold_sec_q;
        hold_min_d = hold_min_q;
        running_d  = running_q;
        frozen_d   = frozen_q;
        overflow_d = overflow_q;
        tick_cs_d  = 1'b0;
        tick_sec_d = 1'b0;
        tick_min_d = 1'b0;

        if (start_stop && ss_allowed) begin
            running_d = !running_q;
        end

        if (tc) begin
            presc_d = '0;
        end else if (running_q) begin
            presc_d = presc_q + PW'(1);
        end

        if (ovf_evt) begin
            overflow_d = 1'b1;
            if (WRAP_EN) begin
                cs_d       = 8'h00;
                sec_d      = 8'h00;
                min_d      = 8'h00;
                tick_cs_d  = 1'b1;
                tick_sec_d = 1'b1;
                tick_min_d = 1'b1;
            end else begin
                running_d = 1'b0;
            end
        end else if (tc) begin
            tick_cs_d = 1'b1;
            cs_d      = cs_wrap ? 8'h00 : bcd_inc(cs_q);
            if (cs_wrap) begin
                tick_sec_d = 1'b1;
                sec_d      = sec_wrap ? 8'h00 : bcd_inc(sec_q);
                if (sec_wrap) begin
                    tick_min_d = 1'b1;
                    min_d      = bcd_inc(min_q);
                end
            end
        end

        if (lap) begin
            if (!frozen_q) begin
                hold_cs_d  = cs_q;
                hold_sec_d = sec_q;
                hold_min_d = min_q;
                frozen_d   = 1'b1;
            end else begin
                frozen_d = 1'b0;
            end
        end

        // clear overrides any coincident increment or lap; running is left alone.
        if (clear) begin
            presc_d    = '0;
            cs_d       = 8'h00;
            sec_d      = 8'h00;
            min_d      = 8'h00;
            overflow_d = 1'b0;
            frozen_d   = 1'b0;
            tick_cs_d  = 1'b0;
            tick_sec_d = 1'b0;
            tick_min_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            presc_q    <= '0;
            cs_q       <= 8'h00;
            sec_q      <= 8'h00;
            min_q      <= 8'h00;
            hold_cs_q  <= 8'h00;
            hold_sec_q <= 8'h00;
            hold_min_q <= 8'h00;
            running_q  <= 1'b0;
            frozen_q   <= 1'b0;
            overflow_q <= 1'b0;
            tick_cs_q  <= 1'b0;
            tick_sec_q <= 1'b0;
            tick_min_q <= 1'b0;
        end else begin
            presc_q    <= presc_d;
            cs_q       <= cs_d;
            sec_q      <= sec_d;
            min_q      <= min_d;
            hold_cs_q  <= hold_cs_d;
            hold_sec_q <= hold_sec_d;
            hold_min_q <= hold_min_d;
            running_q  <= running_d;
            frozen_q   <= frozen_d;
            overflow_q <= overflow_d;
            tick_cs_q  <= tick_cs_d;
            tick_sec_q <= tick_sec_d;
            tick_min_q <= tick_min_d;
        end
    end

    assign running  = running_q;
    assign frozen   = frozen_q;
    assign overflow = overflow_q;
    assign tick_cs  = tick_cs_q;
    assign tick_sec = tick_sec_q;
    assign tick_min = tick_min_q;
    assign cs_bcd   = frozen_q ? hold_cs_q  : cs_q;
    assign sec_bcd  = frozen_q ? hold_sec_q : sec_q;
    assign min_bcd  = frozen_q ? hold_min_q : min_q;

endmodule
